// File: rtl/fma_pkg.sv
// Shared types for the FMA array return path: client encoding, tag layout, lane defaults.
package fma_pkg;
    localparam int BW_FP_DEF = 17;
    localparam int LANES_DEF = 128;

    typedef enum logic [1:0] {
        CL_NONE           = 2'd0,
        CL_ROPE           = 2'd1,
        CL_NORM1          = 2'd2,
        CL_POST_ATTN_NORM = 2'd3
    } client_e;

    typedef struct packed {
        logic       valid;
        client_e    client;
        logic [7:0] lanes;
        logic       wb;
    } tag_t;

    function automatic logic [2:0] client_onehot(input client_e c);
        case (c)
            CL_ROPE:           return 3'b001;
            CL_NORM1:          return 3'b010;
            CL_POST_ATTN_NORM: return 3'b100;
            default:           return 3'b000;
        endcase
    endfunction
endpackage

// File: rtl/fma_wb_fifo.sv
// Write-back FIFO; push while full is accepted only when a pop happens in the same cycle.
module fma_wb_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fma_result_router.sv
// FMA array return path: tag pipeline, per-client result strobe, credit-managed write-back queue.
// Optional per-client result counters under `FMA_RESULT_CNT_EN.
module fma_result_router
    import fma_pkg::*;
#(
    parameter int BW_FP    = BW_FP_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int FMA_LAT  = 4,
    parameter int WB_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [1:0]             issue_client,
    input  logic [7:0]             issue_lanes,
    input  logic                   issue_wb,
    input  logic [LANES*BW_FP-1:0] fma_out,
    output logic                   stall_issue,
    output logic [2:0]             res_valid,
    output logic [LANES*BW_FP-1:0] res_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [LANES*BW_FP-1:0] wb_data,
    output logic [1:0]             wb_client,
    output logic [7:0]             wb_lanes,
    output logic                   err_overflow,
`ifdef FMA_RESULT_CNT_EN
    output logic [47:0]            res_cnt,
`endif
    output logic                   busy
);
    localparam int VW = LANES * BW_FP;
    localparam int FW = VW + 10;
    localparam int CW = $clog2(WB_DEPTH + 1);

    tag_t          tag_q [FMA_LAT];
    tag_t          al;
    logic          al_ok, push, pop;
    int            lanes_eff, pending;
    logic          any_inflight;
    logic [VW-1:0] masked;
    logic [2:0]    res_valid_q;
    logic [VW-1:0] res_data_q;
    logic          err_q;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FMA_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{valid: issue_valid, client: client_e'(issue_client),
                          lanes: issue_lanes, wb: issue_wb};
            for (int k = 1; k < FMA_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign al    = tag_q[FMA_LAT-1];
    assign al_ok = al.valid && (al.client != CL_NONE);

    always_comb begin
        lanes_eff = (al.lanes == 8'd0 || int'(al.lanes) > LANES) ? LANES : int'(al.lanes);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign masked[i*BW_FP +: BW_FP] = (i < lanes_eff) ? fma_out[i*BW_FP +: BW_FP] : '0;
    end

    // Credits cover every wb tag still in the pipe, so a full FIFO is never oversubscribed.
    always_comb begin
        pending      = int'(fifo_cnt);
        any_inflight = 1'b0;
        for (int k = 0; k < FMA_LAT; k++) begin
            if (tag_q[k].valid && tag_q[k].wb) pending = pending + 1;
            any_inflight = any_inflight | tag_q[k].valid;
        end
    end

    assign stall_issue = (pending >= WB_DEPTH);
    assign pop         = wb_ready && !fifo_empty;
    assign push        = al_ok && al.wb && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 3'b000;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= al_ok ? client_onehot(al.client) : 3'b000;
            if (al_ok) res_data_q <= masked;
            if (issue_valid && (issue_client == 2'd0 || (issue_wb && stall_issue)))
                err_q <= 1'b1;
        end
    end

    fma_wb_fifo #(.DW(FW), .DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .data_i ({al.client, 8'(lanes_eff), masked}),
        .data_o (fifo_dout),
        .count_o(fifo_cnt),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign wb_valid     = !fifo_empty;
    assign wb_client    = fifo_dout[FW-1 -: 2];
    assign wb_lanes     = fifo_dout[VW +: 8];
    assign wb_data      = fifo_dout[VW-1:0];
    assign err_overflow = err_q;
    assign busy         = any_inflight || !fifo_empty;

`ifdef FMA_RESULT_CNT_EN
    logic [2:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++)
                if (res_valid_q[c]) cnt_q[c] <= cnt_q[c] + 16'd1;
        end
    end

    assign res_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fma_result_router.sv
// Self-checking bench for fma_result_router: directed scenarios plus a randomized run
// against a cycle-history reference model.
module tb_fma_result_router;
    import fma_pkg::*;

    localparam int BW = 17, LN = 128, VW = BW * LN, LAT = 4, DEP = 4, HN = 1024;

    logic          clk = 1'b0, rst = 1'b1;
    logic          issue_valid = 1'b0, issue_wb = 1'b0, wb_ready = 1'b0;
    logic [1:0]    issue_client = 2'd0;
    logic [7:0]    issue_lanes = 8'd0;
    logic [VW-1:0] fma_out = '0;
    logic          stall_issue, wb_valid, err_overflow, busy;
    logic [2:0]    res_valid;
    logic [VW-1:0] res_data, wb_data;
    logic [1:0]    wb_client;
    logic [7:0]    wb_lanes;
`ifdef FMA_RESULT_CNT_EN
    logic [47:0]   res_cnt;
`endif

    always #5 clk = ~clk;

    fma_result_router dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_client(issue_client),
        .issue_lanes(issue_lanes), .issue_wb(issue_wb),
        .fma_out(fma_out), .stall_issue(stall_issue),
        .res_valid(res_valid), .res_data(res_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_client(wb_client), .wb_lanes(wb_lanes),
        .err_overflow(err_overflow),
`ifdef FMA_RESULT_CNT_EN
        .res_cnt(res_cnt),
`endif
        .busy(busy)
    );

    int checks = 0, failures = 0, cyc = 0, last_rst = -1;

    // Input history, indexed by cycle modulo HN.
    logic          h_v [HN], h_w [HN], h_rdy [HN], h_rst [HN];
    logic [1:0]    h_c [HN];
    logic [7:0]    h_l [HN];
    logic [VW-1:0] h_fma [HN];

    typedef struct {logic [1:0] c; logic [7:0] l; logic [VW-1:0] d;} wb_ent_t;
    wb_ent_t       wbq[$];
    logic [2:0]    e_rv = 3'b000;
    logic [VW-1:0] e_rd = '0;
    logic          e_err = 1'b0, e_stall = 1'b0, e_busy = 1'b0;
    int            e_cnt [3] = '{0, 0, 0};
    bit            fma_hold = 1'b0;

    function automatic int eff(input logic [7:0] l);
        return (l == 8'd0 || int'(l) > LN) ? LN : int'(l);
    endfunction

    function automatic logic [VW-1:0] mask_vec(input logic [VW-1:0] v, input logic [7:0] l);
        logic [VW-1:0] r = '0;
        for (int i = 0; i < eff(l); i++) r[i*BW +: BW] = v[i*BW +: BW];
        return r;
    endfunction

    function automatic logic [2:0] oh(input logic [1:0] c);
        return (c == 2'd0) ? 3'b000 : 3'(1 << (c - 1));
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LN; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    function automatic int first_diff(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < LN; i++) if (a[i*BW +: BW] !== b[i*BW +: BW]) return i;
        return 0;
    endfunction

    task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] l, input logic w);
        issue_valid = v; issue_client = c; issue_lanes = l; issue_wb = w;
    endtask

    // Advance one clock and update the reference model for the new cycle.
    task automatic tick();
        int p, m, sz, pend;
        bit popped;
        p = cyc % HN;
        h_v[p] = issue_valid; h_c[p] = issue_client; h_l[p] = issue_lanes; h_w[p] = issue_wb;
        h_rdy[p] = wb_ready; h_rst[p] = rst; h_fma[p] = fma_out;
        @(posedge clk);
        #1;
        cyc++;
        if (h_rst[p]) begin
            wbq.delete();
            e_err = 0; e_rv = '0; e_rd = '0; e_cnt = '{0, 0, 0};
            last_rst = cyc - 1;
        end else begin
            for (int c = 0; c < 3; c++) if (e_rv[c]) e_cnt[c] = (e_cnt[c] + 1) % 65536;
            if (h_v[p] && (h_c[p] == 2'd0 || (h_w[p] && e_stall))) e_err = 1;
            sz = wbq.size();
            popped = (sz > 0) && h_rdy[p];
            if (popped) void'(wbq.pop_front());
            m = cyc - 1 - LAT;
            e_rv = '0;
            if (m > last_rst && m >= 0 && h_v[m % HN] && h_c[m % HN] != 2'd0) begin
                e_rv = oh(h_c[m % HN]);
                e_rd = mask_vec(h_fma[p], h_l[m % HN]);
                if (h_w[m % HN] && (sz < DEP || popped))
                    wbq.push_back('{h_c[m % HN], 8'(eff(h_l[m % HN])), e_rd});
            end
        end
        pend = wbq.size();
        e_busy = (wbq.size() > 0);
        for (int k = 1; k <= LAT; k++) begin
            m = cyc - k;
            if (m > last_rst && m >= 0 && h_v[m % HN]) begin
                e_busy = 1;
                if (h_w[m % HN]) pend++;
            end
        end
        e_stall = (pend >= DEP);
        if (!fma_hold) fma_out = rand_vec();
    endtask

    task automatic test_reset();
        rst = 1; drive(0, 0, 0, 0);
        repeat (3) tick();
        checks++; if (res_valid !== 3'b000) begin failures++; $display("FAIL reset_res_valid: got %b want 000", res_valid); end
        checks++; if (res_data !== '0) begin failures++; $display("FAIL reset_res_data: nonzero at lane %0d", first_diff(res_data, '0)); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++; if (stall_issue !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall_issue); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_overflow); end
        rst = 0;
    endtask

    task automatic test_single();
        int t0;
        logic [2:0] exp;
        t0 = cyc;
        drive(1, 1, 8'd128, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            exp = (k == 5) ? 3'b001 : 3'b000;
            checks++; if (res_valid !== exp) begin failures++; $display("FAIL single_strobe: t0+%0d got %b want %b", k, res_valid, exp); end
            if (k == 5) begin
                checks++;
                if (res_data !== h_fma[(t0 + 4) % HN]) begin
                    failures++;
                    $display("FAIL single_data: lane %0d got %h want %h", first_diff(res_data, h_fma[(t0 + 4) % HN]),
                             res_data[first_diff(res_data, h_fma[(t0 + 4) % HN])*BW +: BW],
                             h_fma[(t0 + 4) % HN][first_diff(res_data, h_fma[(t0 + 4) % HN])*BW +: BW]);
                end
            end
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL single_wb_valid: got %b want 0", wb_valid); end
            tick();
        end
    endtask

    task automatic test_masked_wb();
        logic [VW-1:0] exp;
        exp = '0;
        for (int i = 0; i < 64; i++) exp[i*BW +: BW] = 17'h1FFFF;
        fma_hold = 1; fma_out = '1; wb_ready = 0;
        drive(1, 3, 8'd64, 1);
        tick();
        drive(0, 0, 0, 0);
        repeat (4) tick();
        checks++; if (res_valid !== 3'b100) begin failures++; $display("FAIL masked_strobe: got %b want 100", res_valid); end
        checks++; if (res_data !== exp) begin failures++; $display("FAIL masked_data: first bad lane %0d", first_diff(res_data, exp)); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL masked_wb_valid: got %b want 1", wb_valid); end
        checks++; if (wb_client !== 2'd3) begin failures++; $display("FAIL masked_wb_client: got %0d want 3", wb_client); end
        checks++; if (wb_lanes !== 8'd64) begin failures++; $display("FAIL masked_wb_lanes: got %0d want 64", wb_lanes); end
        checks++; if (wb_data !== exp) begin failures++; $display("FAIL masked_wb_data: first bad lane %0d", first_diff(wb_data, exp)); end
        fma_hold = 0; wb_ready = 1;
        tick();
        wb_ready = 0;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL masked_drain: got %b want 0", wb_valid); end
    endtask

    task automatic test_credit_stall();
        wb_ready = 0;
        for (int j = 0; j < 4; j++) begin
            drive(1, 2'(1 + $urandom_range(0, 2)), 8'(1 + $urandom_range(0, 127)), 1);
            tick();
            checks++; if (stall_issue !== (j == 3)) begin failures++; $display("FAIL credit_stall_%0d: got %b want %b", j, stall_issue, j == 3); end
        end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL credit_err_early: got %b want 0", err_overflow); end
        drive(1, 2, 8'd32, 1);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL credit_err: got %b want 1", err_overflow); end
        repeat (6) tick();
        checks++; if (stall_issue !== 1'b1) begin failures++; $display("FAIL credit_full_stall: got %b want 1", stall_issue); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL credit_full_valid: got %b want 1", wb_valid); end
    endtask

    task automatic test_full_push_pop();
        int pops = 0;
        drive(1, 1, 8'd100, 1);
        tick();
        drive(0, 0, 0, 0);
        repeat (3) tick();
        wb_ready = 1;
        for (int k = 0; k < 10; k++) begin
            checks++; if (wb_valid !== (wbq.size() > 0)) begin failures++; $display("FAIL fullpp_valid_%0d: got %b want %b", k, wb_valid, wbq.size() > 0); end
            if (wbq.size() > 0) begin
                checks++;
                if (wb_client !== wbq[0].c || wb_lanes !== wbq[0].l || wb_data !== wbq[0].d) begin
                    failures++;
                    $display("FAIL fullpp_head_%0d: got client %0d lanes %0d want client %0d lanes %0d (data lane %0d)",
                             k, wb_client, wb_lanes, wbq[0].c, wbq[0].l, first_diff(wb_data, wbq[0].d));
                end
            end
            if (wb_valid === 1'b1) pops++;
            tick();
        end
        wb_ready = 0;
        checks++; if (pops !== 5) begin failures++; $display("FAIL fullpp_pops: got %0d want 5", pops); end
    endtask

    task automatic test_reset_midflight();
        for (int j = 1; j <= 3; j++) begin
            drive(1, 2'(j), 8'd16, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (res_valid !== 3'b000 || wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_%0d: res_valid %b wb_valid %b want 000/0", k, res_valid, wb_valid); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b want 0", err_overflow); end
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [2:0] exp;
        rst = 1; tick(); rst = 0;
        t0 = cyc;
        for (int j = 1; j <= 3; j++) begin
            drive(1, 2'(j), 8'(40 * j), 0);
            tick();
        end
        drive(0, 0, 0, 0);
        while (cyc < t0 + 9) begin
            exp = (cyc - t0 == 5) ? 3'b001 : (cyc - t0 == 6) ? 3'b010 : (cyc - t0 == 7) ? 3'b100 : 3'b000;
            checks++; if (res_valid !== exp) begin failures++; $display("FAIL b2b_strobe: t0+%0d got %b want %b", cyc - t0, res_valid, exp); end
            tick();
        end
`ifdef FMA_RESULT_CNT_EN
        checks++; if (res_cnt !== {16'd1, 16'd1, 16'd1}) begin failures++; $display("FAIL b2b_cnt: got %h want 000100010001", res_cnt); end
`endif
    endtask

    task automatic test_random();
        logic v, w;
        logic [1:0] c;
        logic [7:0] l;
        for (int n = 0; n < 400; n++) begin
            checks++; if (res_valid !== e_rv) begin failures++; $display("FAIL rnd_strobe @%0d: got %b want %b", cyc, res_valid, e_rv); end
            checks++; if (res_data !== e_rd) begin failures++; $display("FAIL rnd_data @%0d: lane %0d differs", cyc, first_diff(res_data, e_rd)); end
            checks++; if (wb_valid !== (wbq.size() > 0)) begin failures++; $display("FAIL rnd_wb_valid @%0d: got %b want %b", cyc, wb_valid, wbq.size() > 0); end
            if (wbq.size() > 0) begin
                checks++;
                if (wb_client !== wbq[0].c || wb_lanes !== wbq[0].l || wb_data !== wbq[0].d) begin
                    failures++;
                    $display("FAIL rnd_wb_head @%0d: got client %0d lanes %0d want client %0d lanes %0d", cyc, wb_client, wb_lanes, wbq[0].c, wbq[0].l);
                end
            end
            checks++; if (stall_issue !== e_stall) begin failures++; $display("FAIL rnd_stall @%0d: got %b want %b", cyc, stall_issue, e_stall); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy, e_busy); end
            checks++; if (err_overflow !== e_err) begin failures++; $display("FAIL rnd_err @%0d: got %b want %b", cyc, err_overflow, e_err); end
            v = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'(1 + $urandom_range(0, 2));
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'(1 + $urandom_range(0, 127));
            w = (!e_stall && $urandom_range(0, 1) == 1) || ($urandom_range(0, 31) == 0);
            drive(v, c, l, w);
            wb_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(0, 0, 0, 0);
`ifdef FMA_RESULT_CNT_EN
        for (int k = 0; k < 3; k++) begin
            checks++; if (res_cnt[16*k +: 16] !== 16'(e_cnt[k])) begin failures++; $display("FAIL rnd_cnt%0d: got %0d want %0d", k, res_cnt[16*k +: 16], e_cnt[k]); end
        end
`endif
    endtask

    initial begin
        fma_out = rand_vec();
        test_reset();
        test_single();
        test_masked_wb();
        test_credit_stall();
        test_full_push_pop();
        test_reset_midflight();
        test_back_to_back();
        rst = 1; tick(); rst = 0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
